upsamp_module: RTL and testbench

- I-branch transmit front end of the QAM modulator.
- Maps each 4-bit symbol to a signed I amplitude and upsamples it by zero-stuffing to a programmable rate.
- Passes the upsampled stream through a programmable-coefficient FIR pulse-shaping filter.
- Feeds the downstream output storage/validation stage with both the upsampled I sample and the filtered sample.

---
 rtl/upsamp_module.sv | 125 ++++++++++++
 tb/tb_upsamp_module.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/upsamp_module.sv
// I-branch transmit front end: Gray symbol-to-level map, zero-stuffing upsampler and
// programmable-coefficient FIR pulse shaper. Define UPSAMP_SAT_EN to saturate the FIR output.
module upsamp_module #(
  parameter int unsigned NTAPS     = 71,
  parameter int unsigned OUT_SHIFT = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          data_in,
  input  logic signed [6:0]   addr,
  input  logic signed [7:0]   coefficient,
  input  logic                write_en,
  input  logic                valid_data,
  input  logic [8:0]          upsampling_rate,
  output logic signed [9:0]   I_out,
  output logic signed [11:0]  filtered_output
);

  localparam int unsigned SYM_W  = 10;
  localparam int unsigned COEF_W = 8;
  localparam int unsigned OUT_W  = 12;
  localparam int unsigned RATE_W = 9;
  localparam int unsigned CNT_W  = RATE_W + 1;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned PROD_W = SYM_W + COEF_W;
  localparam int unsigned ACC_W  = PROD_W + $clog2(NTAPS);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2047);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-2048);

  logic signed [COEF_W-1:0] coef [NTAPS];
  logic signed [SYM_W-1:0]  hist [NTAPS-1];
  logic [RATE_W-1:0]        phase;

  logic [ADDR_W-1:0]        addr_u_c;
  logic                     coef_we_c;
  logic [RATE_W-1:0]        leff_c;
  logic [CNT_W-1:0]         phase_inc_c;
  logic                     phase_wrap_c;
  logic signed [SYM_W-1:0]  level_c;
  logic signed [ACC_W-1:0]  acc_c;
  logic signed [ACC_W-1:0]  acc_sh_c;
  logic signed [OUT_W-1:0]  filt_c;
  logic                     unused_sym_bits_c;

  assign unused_sym_bits_c = ^data_in[1:0];

  // Addresses 64..70 only exist as 7'h40..7'h46, so decode the address as unsigned;
  // 7'h7F (-1) and every other code past NTAPS-1 falls outside the RAM.
  assign addr_u_c  = $unsigned(addr);
  assign coef_we_c = write_en && (32'(addr_u_c) < NTAPS);

  always_ff @(posedge clk) begin
    if (coef_we_c) begin
      coef[addr_u_c] <= coefficient;
    end
  end

  // Rate and phase bookkeeping; a rate of 0 behaves as 1
  always_comb begin
    leff_c       = (upsampling_rate == '0) ? RATE_W'(1) : upsampling_rate;
    phase_inc_c  = CNT_W'(phase) + CNT_W'(1);
    phase_wrap_c = (phase_inc_c >= CNT_W'(leff_c));
  end

  // Gray-coded I level
  always_comb begin
    level_c = '0;
    unique case (data_in[3:2])
      2'b00:   level_c = SYM_W'(-3);
      2'b01:   level_c = SYM_W'(-1);
      2'b11:   level_c = SYM_W'(1);
      default: level_c = SYM_W'(3);
    endcase
  end

  // FIR sum over the current I_out and its NTAPS-1 predecessors
  always_comb begin
    logic signed [PROD_W-1:0] prod;
    prod  = PROD_W'(coef[0]) * PROD_W'(I_out);
    acc_c = ACC_W'(prod);
    for (int k = 1; k < int'(NTAPS); k++) begin
      prod  = PROD_W'(coef[k]) * PROD_W'(hist[k-1]);
      acc_c = acc_c + ACC_W'(prod);
    end
    acc_sh_c = acc_c >>> OUT_SHIFT;
  end

  always_comb begin
    filt_c = OUT_W'(acc_sh_c);
`ifdef UPSAMP_SAT_EN
    if (acc_sh_c > SAT_MAX) begin
      filt_c = OUT_W'(SAT_MAX);
    end else if (acc_sh_c < SAT_MIN) begin
      filt_c = OUT_W'(SAT_MIN);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      I_out           <= '0;
      phase           <= '0;
      filtered_output <= '0;
      for (int k = 0; k < int'(NTAPS) - 1; k++) begin
        hist[k] <= '0;
      end
    end else begin
      if (!valid_data) begin
        I_out <= '0;
        phase <= '0;
      end else begin
        I_out <= (phase == '0) ? level_c : '0;
        phase <= phase_wrap_c ? '0 : RATE_W'(phase_inc_c);
      end
      // Delay line shifts every cycle so zeros flush through when idle
      hist[0] <= I_out;
      for (int k = 1; k < int'(NTAPS) - 1; k++) begin
        hist[k] <= hist[k-1];
      end
      filtered_output <= filt_c;
    end
  end

endmodule

// File: tb/tb_upsamp_module.sv
// Directed self-checking bench for upsamp_module: coefficient load, impulse response,
// address guard, write/filter ordering, upsampling, DC ramp and mid-stream reset.
module tb_upsamp_module;

  localparam int NTAPS = 71;

  logic               clk = 1'b0;
  logic               rst;
  logic [3:0]         data_in;
  logic signed [6:0]  addr;
  logic signed [7:0]  coefficient;
  logic               write_en;
  logic               valid_data;
  logic [8:0]         upsampling_rate;
  logic signed [9:0]  I_out;
  logic signed [11:0] filtered_output;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  upsamp_module #(.NTAPS(NTAPS), .OUT_SHIFT(0)) dut (
    .clk             (clk),
    .rst             (rst),
    .data_in         (data_in),
    .addr            (addr),
    .coefficient     (coefficient),
    .write_en        (write_en),
    .valid_data      (valid_data),
    .upsampling_rate (upsampling_rate),
    .I_out           (I_out),
    .filtered_output (filtered_output)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int narrow(input int v);
    logic signed [11:0] w;
`ifdef UPSAMP_SAT_EN
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
`else
    w = 12'(v);
    return int'(w);
`endif
  endfunction

  // Constant +3 input with coef[k]=k: t ticks after valid rises the sum covers taps 0..t-2
  function automatic int dc_expect(input int t);
    int s;
    s = 0;
    for (int k = 0; k <= t - 2 && k < NTAPS; k++) s += 3 * k;
    return narrow(s);
  endfunction

  task automatic run_impulse(input string tag);
    upsampling_rate = 9'd1;
    data_in         = 4'b1010;
    valid_data      = 1'b1;
    tick();
    chk({tag, "_i_hi"}, I_out, 3);
    valid_data = 1'b0;
    for (int k = 0; k <= NTAPS; k++) begin
      tick();
      chk($sformatf("%s_i_k%0d", tag, k), I_out, 0);
      chk($sformatf("%s_f_k%0d", tag, k), filtered_output, (k < NTAPS) ? 3 * k : 0);
    end
  endtask

  task automatic run_dc(input string tag);
    upsampling_rate = 9'd0;
    data_in         = 4'b1010;
    valid_data      = 1'b1;
    for (int t = 1; t <= 80; t++) begin
      tick();
      if (t == 1 || t == 80) chk($sformatf("%s_i_t%0d", tag, t), I_out, 3);
      if (t == 1 || t == 2 || t == 3 || t == 32 || t == 42 || t == 72 || t == 80)
        chk($sformatf("%s_f_t%0d", tag, t), filtered_output, dc_expect(t));
    end
  endtask

  initial begin
    rst             = 1'b1;
    data_in         = 4'b0000;
    addr            = '0;
    coefficient     = '0;
    write_en        = 1'b0;
    valid_data      = 1'b0;
    upsampling_rate = 9'd1;
    tick();
    tick();
    chk("rst_i", I_out, 0);
    chk("rst_f", filtered_output, 0);

    // Load coef[i]=i while held in reset
    for (int i = 0; i < NTAPS; i++) begin
      addr        = 7'(i);
      coefficient = 8'(i);
      write_en    = 1'b1;
      tick();
    end
    write_en = 1'b0;
    chk("load_rst_i", I_out, 0);
    chk("load_rst_f", filtered_output, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_i", I_out, 0);
    chk("post_rst_f", filtered_output, 0);

    run_impulse("imp");

    // Out-of-range addresses must not touch the RAM
    write_en    = 1'b1;
    coefficient = 8'sd5;
    addr        = 7'h7F;
    tick();
    addr = 7'd71;
    tick();
    addr = 7'h50;
    tick();
    write_en = 1'b0;
    run_impulse("guard");

    // Write lands after the edge it shares with the filter sum
    upsampling_rate = 9'd1;
    data_in         = 4'b1010;
    valid_data      = 1'b1;
    tick();
    valid_data = 1'b0;
    tick();
    chk("wr_f_e1", filtered_output, 0);
    write_en    = 1'b1;
    addr        = 7'd2;
    coefficient = 8'sd20;
    tick();
    chk("wr_f_e2", filtered_output, 3);
    coefficient = 8'sd2;
    tick();
    chk("wr_f_e3_new", filtered_output, 60);
    write_en = 1'b0;
    tick();
    chk("wr_f_e4", filtered_output, 9);
    for (int i = 0; i < 75; i++) tick();
    chk("wr_flush_f", filtered_output, 0);

    // Upsample by 4; mid-period data change waits for phase 0
    upsampling_rate = 9'd4;
    data_in         = 4'b0101;
    valid_data      = 1'b1;
    tick();
    chk("up_a", I_out, -1);
    tick();
    chk("up_b", I_out, 0);
    data_in = 4'b1010;
    tick();
    chk("up_c", I_out, 0);
    tick();
    chk("up_d", I_out, 0);
    tick();
    chk("up_e", I_out, 3);
    data_in = 4'b1111;
    tick();
    chk("up_f", I_out, 0);
    tick();
    chk("up_g", I_out, 0);
    tick();
    chk("up_h", I_out, 0);
    tick();
    chk("up_i", I_out, 1);
    // Phase is 1; dropping to L=2 wraps on the next edge
    upsampling_rate = 9'd2;
    data_in         = 4'b0000;
    tick();
    chk("rate2_j", I_out, 0);
    tick();
    chk("rate2_k", I_out, -3);
    tick();
    chk("rate2_l", I_out, 0);
    upsampling_rate = 9'd0;
    tick();
    chk("rate0_m", I_out, -3);
    data_in = 4'b0101;
    tick();
    chk("rate0_n", I_out, -1);
    valid_data = 1'b0;
    tick();
    chk("idle_i", I_out, 0);
    for (int i = 0; i < 75; i++) tick();
    chk("up_flush_f", filtered_output, 0);

    run_dc("dc");

    // One-cycle reset mid-stream, then the ramp resumes from scratch
    rst = 1'b1;
    tick();
    chk("midrst_i", I_out, 0);
    chk("midrst_f", filtered_output, 0);
    rst = 1'b0;
    run_dc("dc2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
